// File: rtl/debounce_pkg.sv
// Shared types for the debounce block: FSM state encoding and event-counter sizing.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        CHK_HIGH  = 2'd1,
        IDLE_HIGH = 2'd2,
        CHK_LOW   = 2'd3
    } deb_state_t;

    localparam int                   EVT_CNT_W   = 8;
    localparam logic [EVT_CNT_W-1:0] EVT_CNT_MAX = 8'hFF;

    function automatic logic is_chk(input deb_state_t st);
        return (st == CHK_HIGH) || (st == CHK_LOW);
    endfunction

endpackage

// File: rtl/sync_chain_rstn.sv
// Purpose: plain flop-chain synchronizer for a single asynchronous level.
// Latency: STAGES cycles from sampling edge to q.
// Backpressure: none; free-running level path.
module sync_chain_rstn #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    generate
        if (STAGES < 2) begin : g_bad_stages
            $error("sync_chain_rstn: STAGES must be >= 2");
        end
    endgenerate

    logic [STAGES-1:0] sync_q;

    // No logic between stages so every flop after the first gets a full cycle to resolve.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/debounce_sync_rstn.sv
// Purpose: synchronize + debounce a raw input into a level, latch strobe and rise/fall pulses.
// Latency: d_out moves SYNC_STAGES+DEBOUNCE_CYCLES edges after the new level is first sampled.
// Backpressure: none. Optional event counter enabled by DEBOUNCE_EVT_CNT_EN.
module debounce_sync_rstn
    import debounce_pkg::*;
#(
    parameter  int SYNC_STAGES     = 2,
    parameter  int DEBOUNCE_CYCLES = 16,
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 din_async,
`ifdef DEBOUNCE_EVT_CNT_EN
    input  logic                 evt_clr,
    output logic [EVT_CNT_W-1:0] evt_count,
`endif
    output logic                 d_out,
    output logic                 latch_en,
    output logic                 rise_pulse,
    output logic                 fall_pulse,
    output logic                 busy
);

    generate
        if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
            $error("debounce_sync_rstn: DEBOUNCE_CYCLES must be >= 2");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic       sync_s;
    deb_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic       dout_q, dout_d;
    logic       rise_q, rise_d;
    logic       fall_q, fall_d;
    logic       busy_q, busy_d;

    sync_chain_rstn #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (din_async),
        .q       (sync_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            IDLE_LOW: begin
                if (sync_s) begin
                    state_d = CHK_HIGH;
                    cnt_d   = CNT_ONE;
                end
            end
            CHK_HIGH: begin
                // Any reverted sample, even on the final count, discards the candidate edge.
                if (!sync_s) begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_HIGH;
                    cnt_d   = '0;
                    dout_d  = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            IDLE_HIGH: begin
                if (!sync_s) begin
                    state_d = CHK_LOW;
                    cnt_d   = CNT_ONE;
                end
            end
            CHK_LOW: begin
                if (sync_s) begin
                    state_d = IDLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                    dout_d  = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE_LOW;
                cnt_d   = '0;
            end
        endcase
        busy_d = is_chk(state_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= busy_d;
        end
    end

    assign d_out      = dout_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign latch_en   = rise_q | fall_q;
    assign busy       = busy_q;

`ifdef DEBOUNCE_EVT_CNT_EN
    logic [EVT_CNT_W-1:0] evt_cnt_q, evt_cnt_d;

    // Updates on the same edge that raises latch_en; a coincident clear takes priority.
    always_comb begin
        evt_cnt_d = evt_cnt_q;
        if (evt_clr) begin
            evt_cnt_d = '0;
        end else if ((rise_d | fall_d) && (evt_cnt_q != EVT_CNT_MAX)) begin
            evt_cnt_d = evt_cnt_q + EVT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            evt_cnt_q <= '0;
        end else begin
            evt_cnt_q <= evt_cnt_d;
        end
    end

    assign evt_count = evt_cnt_q;
`endif

endmodule

// File: tb/tb_debounce_sync_rstn.sv
// Bench for debounce_sync_rstn (SYNC_STAGES=2, DEBOUNCE_CYCLES=4): directed steps plus random runs
// against a run-length reference model.
module tb_debounce_sync_rstn;

    localparam int SYNC = 2;
    localparam int DC   = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       din_async;
    logic       evt_clr;
    logic [7:0] evt_count;
    logic       d_out, latch_en, rise_pulse, fall_pulse, busy;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    logic dq[$];
    logic m_d, m_rise, m_fall, m_busy;
    int   m_run;
    int   m_evt;

    always #5 clk = ~clk;

    debounce_sync_rstn #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .din_async  (din_async),
`ifdef DEBOUNCE_EVT_CNT_EN
        .evt_clr    (evt_clr),
        .evt_count  (evt_count),
`endif
        .d_out      (d_out),
        .latch_en   (latch_en),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .busy       (busy)
    );

`ifndef DEBOUNCE_EVT_CNT_EN
    assign evt_count = 8'h00;
`endif

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        dq.delete();
        for (int i = 0; i < SYNC; i++) dq.push_back(1'b0);
        m_d = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_busy = 1'b0;
        m_run = 0; m_evt = 0;
    endtask

    task automatic chk_all(input string where);
        chk({where, ":d_out"},      int'(d_out),      int'(m_d));
        chk({where, ":latch_en"},   int'(latch_en),   int'(m_rise | m_fall));
        chk({where, ":rise_pulse"}, int'(rise_pulse), int'(m_rise));
        chk({where, ":fall_pulse"}, int'(fall_pulse), int'(m_fall));
        chk({where, ":busy"},       int'(busy),       int'(m_busy));
`ifdef DEBOUNCE_EVT_CNT_EN
        chk({where, ":evt_count"},  int'(evt_count),  m_evt);
`endif
    endtask

    // One clock: drive din, advance the model on the edge, compare on the falling edge.
    task automatic tick(input logic din, input string where);
        logic s;
        din_async = din;
        @(posedge clk);
        s = dq.pop_front();
        dq.push_back(din);
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (s != m_d) begin
            m_run++;
            if (m_run == DC) begin
                m_d   = s;
                m_run = 0;
                if (s) m_rise = 1'b1;
                else   m_fall = 1'b1;
            end
        end else begin
            m_run = 0;
        end
        m_busy = (m_run != 0);
        if (evt_clr) m_evt = 0;
        else if ((m_rise || m_fall) && m_evt < 255) m_evt++;
        @(negedge clk);
        chk_all(where);
    endtask

    initial begin
        int bc;
        logic nv;
        reset_n   = 1'b0;
        din_async = 1'b1;
        evt_clr   = 1'b0;
        model_reset();

        // Reset held with din high: everything quiet.
        repeat (3) begin
            @(negedge clk);
            chk_all("in_reset");
        end
        reset_n = 1'b1;
        model_reset();
        for (int i = 1; i <= 7; i++) begin
            tick(1'b1, "post_reset");
            if (i == 5) chk("rise_not_before_edge6", int'(d_out), 0);
            if (i == 6) chk("rise_at_edge6", int'(rise_pulse & latch_en & d_out), 1);
            if (i == 7) chk("rise_clear_edge7", int'(latch_en), 0);
        end

        // Clean fall.
        for (int i = 1; i <= 10; i++) begin
            tick(1'b0, "clean_fall");
            if (i == 6) chk("fall_at_edge6", int'(fall_pulse & latch_en), 1);
        end
        chk("fall_level", int'(d_out), 0);

        // Glitch of 3 cycles reverts on the final count: rejected.
        bc = 0;
        for (int i = 0; i < 9; i++) begin
            tick((i < 3) ? 1'b1 : 1'b0, "glitch");
            bc += int'(busy);
            chk("glitch_no_latch", int'(latch_en), 0);
        end
        chk("glitch_busy_cycles", bc, 3);
        chk("glitch_level", int'(d_out), 0);

        // One cycle longer: accepted.
        for (int i = 1; i <= 6; i++) begin
            tick((i <= 4) ? 1'b1 : 1'b0, "boundary_accept");
            if (i == 6) chk("boundary_rise", int'(rise_pulse), 1);
        end
        repeat (10) tick(1'b0, "settle_low");

        // Reset mid-check on a rising candidate.
        repeat (4) tick(1'b1, "mid_chk_rise");
        chk("mid_chk_busy", int'(busy), 1);
        #1 reset_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_busy", int'(busy), 0);
        chk_all("async_rst");
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick(1'b1, "rerise");
            if (i == 5) chk("rerise_not_early", int'(d_out), 0);
            if (i == 6) chk("rerise_at_edge6", int'(rise_pulse), 1);
        end

        // Reset while checking a fall from d_out=1: level drops without a pulse.
        repeat (4) tick(1'b0, "mid_chk_fall");
        chk("mid_chk_fall_dout", int'(d_out), 1);
        #1 reset_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_dout", int'(d_out), 0);
        chk_all("async_rst2");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) tick(1'b0, "after_rst2");

        // Random run lengths.
        for (int r = 0; r < 80; r++) begin
            nv = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 8)) tick(nv, "random");
        end

`ifdef DEBOUNCE_EVT_CNT_EN
        for (int i = 0; i < 300; i++) begin
            nv = ~m_d;
            repeat (6) tick(nv, "evt_toggle");
        end
        chk("evt_saturated", int'(evt_count), 255);
        nv = ~m_d;
        repeat (5) tick(nv, "evt_clr_pre");
        evt_clr = 1'b1;
        tick(nv, "evt_clr_hit");
        evt_clr = 1'b0;
        chk("evt_clr_with_latch", int'(latch_en), 1);
        chk("evt_clr_wins", int'(evt_count), 0);
        nv = ~m_d;
        repeat (6) tick(nv, "evt_after_clr");
        chk("evt_count_one", int'(evt_count), 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/debounce_sync_rstn.md
Name: debounce_sync_rstn

Overview:
- Conditions a raw asynchronous input (switch, pin, cross-domain level) into a clean, debounced level for the downstream gated D latch (d_latch_asyn_rstn).
- Stage chain: synchronizer, debounce FSM, stable level (d_out → latch D), one-cycle gate strobe (latch_en → latch clk).
- Also emits rise/fall event pulses for control logic.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops; legal range ≥2, elaboration error otherwise.
- DEBOUNCE_CYCLES, 16, consecutive stable synchronized samples required to accept a new level; legal range ≥2.
- CNT_W, $clog2(DEBOUNCE_CYCLES)+1, debounce counter width (derived, not overridden).

Ports:
- clk  input  1  single system clock, rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- din_async  input  1  raw asynchronous input.
- d_out  output  1  debounced level, registered; drives latch D.
- latch_en  output  1  one-cycle strobe when d_out changes; drives latch gate.
- rise_pulse  output  1  one-cycle pulse on accepted 0→1.
- fall_pulse  output  1  one-cycle pulse on accepted 1→0.
- busy  output  1  high while the FSM is in a CHK state.

Behaviour:
- Interface (already decided): one clock, clk; reset reset_n, asynchronous assert, active-low. Release is synchronous to clk by the system reset tree.
- Reset state:
  - d_out, latch_en, rise_pulse, fall_pulse, busy = 0.
  - Sync chain all 0; counter 0; state IDLE_LOW.
- Synchronizer: s = last stage of the SYNC_STAGES flop chain. No logic between stages.
- FSM states: IDLE_LOW, CHK_HIGH, IDLE_HIGH, CHK_LOW.
  - IDLE_LOW: s==1 → CHK_HIGH, counter←1; else stay.
  - CHK_HIGH: s==0 → IDLE_LOW, counter←0, no pulses (glitch rejected). s==1 and counter==DEBOUNCE_CYCLES-1 → IDLE_HIGH. Otherwise counter+1.
  - IDLE_HIGH / CHK_LOW: mirror image with polarity inverted.
- Outputs on transitions:
  - Entering IDLE_HIGH from CHK_HIGH: d_out←1, latch_en←1, rise_pulse←1 on that same edge. Pulses clear on the next edge.
  - Entering IDLE_LOW from CHK_LOW: d_out←0, latch_en←1, fall_pulse←1. Pulses clear on the next edge.
- Latency: d_out changes exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges after the first edge at which din_async is sampled at its new stable value.
- busy = registered (state ∈ {CHK_HIGH, CHK_LOW}).
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around possible.
- Boundary conditions:
  - Input toggling faster than DEBOUNCE_CYCLES: d_out never changes; busy toggles.
  - Glitch reverting on the last CHK cycle (counter==DEBOUNCE_CYCLES-1 with s reverted): rejected.
  - rise_pulse and fall_pulse are never high together. latch_en == rise_pulse | fall_pulse at all times.
  - Reset asserted mid-CHK: immediate return to reset state, no pulse. After release, a held-high input needs the full latency again.
  - Input held high through reset release: accepted as a 0→1 event after full latency.

Optional Feature:
- Macro: DEBOUNCE_EVT_CNT_EN.
- Defined:
  - Adds output evt_count[7:0]: count of accepted transitions (rise or fall), incremented in the same cycle as latch_en.
  - Saturates at 255, no wrap. Reset value 0.
  - Adds input evt_clr (1 bit), synchronous clear. If evt_clr and latch_en occur together, the result is 0 (clear wins).
- Undefined: neither port exists; no counter logic; all other behaviour identical.

Decomposition:
- Package debounce_pkg:
  - typedef enum logic [1:0] deb_state_t {IDLE_LOW, CHK_HIGH, IDLE_HIGH, CHK_LOW}.
  - localparam EVT_CNT_W = 8; EVT_CNT_MAX = 8'hFF.
- Sub-module sync_chain_rstn: parameter STAGES; ports clk, reset_n, d, q; reset value 0. Reusable elsewhere in the codebase.
- FSM, counter and output registers stay in debounce_sync_rstn.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4 unless noted):
- Reset: hold reset_n=0 for 3 cycles with din_async=1 → all outputs 0. Release → d_out=1, latch_en=rise_pulse=1, on the 6th edge after release; pulses are 0 on the 7th edge.
- Glitch: din_async 0→1 for 3 cycles then back to 0 → d_out stays 0, no pulses; busy=1 for 3 cycles.
- Clean fall: from d_out=1, din_async→0 held 10 cycles → fall_pulse and latch_en one cycle, 6 edges after the change; d_out=0 thereafter.
- Reset mid-check: din_async→1, assert reset_n=0 at edge 4 → outputs 0 asynchronously (before the next clk edge). Release with din still 1 → rise after full 6-edge latency.
- Boundary: revert exactly at counter==3 → rejected. Hold one cycle longer → accepted. Confirms strict DEBOUNCE_CYCLES count.
- DEBOUNCE_EVT_CNT_EN: 300 alternating accepted transitions → evt_count=255. evt_clr coincident with latch_en → evt_count=0.
